galois_lfsr_checker: RTL and testbench

//   PRBS checker for the parallel state stream of galois_lfsr. It takes the WIDTH-bit value

---
 rtl/galois_lfsr_checker.sv | 117 +++++++++++
 tb/tb_galois_lfsr_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/galois_lfsr_checker.sv
// rtl/galois_lfsr_checker.sv - self-synchronising PRBS checker for the galois_lfsr state stream
// Seeds from received beats while searching; once locked, predicts from its own state and counts misses.
module galois_lfsr_checker #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-2:0] TAPS         = 7'b0111000,
  parameter int               LOCK_COUNT   = 4,
  parameter int               UNLOCK_COUNT = 3,
  parameter int               COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   data_valid,
  input  logic [WIDTH-1:0]       data,
  output logic                   locked,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] error_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_LAST   = MW'(LOCK_COUNT);
  localparam logic [UW-1:0] UNLOCK_LAST = UW'(UNLOCK_COUNT);

  typedef enum logic {SEARCH, LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       expected_q, expected_d;
  logic                   have_seed_q, have_seed_d;
  logic [MW-1:0]          match_run_q, match_run_d;
  logic [UW-1:0]          miss_run_q, miss_run_d;
  logic                   error_q, error_d;
  logic [COUNT_WIDTH-1:0] error_count_q, error_count_d;
  logic                   hit;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v);
    return {v[0], ({(WIDTH-1){v[0]}} & TAPS) ^ v[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= SEARCH;
      expected_q    <= '0;
      have_seed_q   <= 1'b0;
      match_run_q   <= '0;
      miss_run_q    <= '0;
      error_q       <= 1'b0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      have_seed_q   <= have_seed_d;
      match_run_q   <= match_run_d;
      miss_run_q    <= miss_run_d;
      error_q       <= error_d;
      error_count_q <= error_count_d;
    end
  end

  // All-zero data is the LFSR lock-up state, so it can neither seed nor hit.
  assign hit = have_seed_q && (data == expected_q) && (data != '0);

  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    have_seed_d   = have_seed_q;
    match_run_d   = match_run_q;
    miss_run_d    = miss_run_q;
    error_d       = 1'b0;
    error_count_d = error_count_q;

    if (data_valid) begin
      unique case (state_q)
        SEARCH: begin
          expected_d  = step(data);
          have_seed_d = (data != '0);
          if (hit) begin
            match_run_d = match_run_q + 1'b1;
            if (match_run_d == LOCK_LAST) begin
              state_d    = LOCKED;
              miss_run_d = '0;
            end
          end else begin
            match_run_d = '0;
          end
        end
        LOCKED: begin
          // Prediction free-runs so a corrupt beat cannot poison later ones.
          expected_d = step(expected_q);
          if (data != expected_q) begin
            error_d = 1'b1;
            if (error_count_q != '1) error_count_d = error_count_q + 1'b1;
            miss_run_d = miss_run_q + 1'b1;
            if (miss_run_d == UNLOCK_LAST) begin
              state_d     = SEARCH;
              match_run_d = '0;
              have_seed_d = 1'b0;
            end
          end else begin
            miss_run_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clear) begin
      error_d       = 1'b0;
      error_count_d = '0;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign error       = error_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_galois_lfsr_checker.sv
// tb/tb_galois_lfsr_checker.sv - directed bench for galois_lfsr_checker
// Two instances share stimulus: default 16-bit counter and a 4-bit counter for saturation.
module tb_galois_lfsr_checker;

  logic        clock;
  logic        resetn;
  logic        clear;
  logic        data_valid;
  logic [7:0]  data;
  logic        locked, error;
  logic [15:0] error_count;
  logic        locked4, error4;
  logic [3:0]  error_count4;

  int checks = 0;
  int errors = 0;
  logic [7:0] g;
  logic [7:0] head [5];
  logic       found;

  galois_lfsr_checker dut (
    .clock(clock), .resetn(resetn), .clear(clear), .data_valid(data_valid), .data(data),
    .locked(locked), .error(error), .error_count(error_count)
  );

  galois_lfsr_checker #(.COUNT_WIDTH(4)) dut_c4 (
    .clock(clock), .resetn(resetn), .clear(clear), .data_valid(data_valid), .data(data),
    .locked(locked4), .error(error4), .error_count(error_count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Generator model: WIDTH=8, TAPS=7'b0111000.
  function automatic logic [7:0] gen_step(input logic [7:0] v);
    return {v[0], ({7{v[0]}} & 7'b0111000) ^ v[7:1]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [7:0] d, input logic clr);
    @(negedge clock);
    data_valid = v;
    data       = d;
    clear      = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn     = 1'b0;
    data_valid = 1'b0;
    data       = 8'h00;
    clear      = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("reset_locked", locked, 0);
    check_eq("reset_error", error, 0);
    check_eq("reset_count", error_count, 0);
    resetn = 1'b1;
  endtask

  initial begin
    head[0] = 8'h01; head[1] = 8'hB8; head[2] = 8'h5C; head[3] = 8'h2E; head[4] = 8'h17;
    resetn = 1'b1; clear = 1'b0; data_valid = 1'b0; data = 8'h00;

    // 1: lock on the 5th clean beat, then 300 error-free beats
    do_reset();
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, head[i], 1'b0);
      check_eq($sformatf("t1_lock_beat%0d", i + 1), locked, (i == 4) ? 1 : 0);
    end
    g = gen_step(8'h17);
    for (int i = 0; i < 300; i++) begin
      beat(1'b1, g, 1'b0);
      g = gen_step(g);
      check_eq("t1_no_error", error, 0);
    end
    check_eq("t1_count", error_count, 0);
    check_eq("t1_locked", locked, 1);

    // 2: single corrupt beat 0x2F in place of 0x2E
    found = 1'b0;
    for (int i = 0; i < 260 && !found; i++) begin
      if (g == 8'h2E) found = 1'b1;
      else begin
        beat(1'b1, g, 1'b0);
        g = gen_step(g);
      end
    end
    check_eq("t2_found_2e", found, 1);
    beat(1'b1, 8'h2F, 1'b0);
    g = gen_step(g);
    check_eq("t2_error", error, 1);
    check_eq("t2_count", error_count, 1);
    check_eq("t2_locked", locked, 1);
    beat(1'b1, g, 1'b0);
    g = gen_step(g);
    check_eq("t2_next_data", {24'h0, data}, 32'h17);
    check_eq("t2_next_ok", error, 0);
    check_eq("t2_next_locked", locked, 1);

    // 3: three corrupt beats unlock, five clean beats relock
    beat(1'b1, g, 1'b1);
    g = gen_step(g);
    check_eq("t3_cleared", error_count, 0);
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, g ^ 8'h40, 1'b0);
      g = gen_step(g);
      check_eq($sformatf("t3_err%0d", i + 1), error, 1);
      check_eq($sformatf("t3_locked%0d", i + 1), locked, (i == 2) ? 0 : 1);
    end
    check_eq("t3_count", error_count, 3);
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, g, 1'b0);
      g = gen_step(g);
      check_eq($sformatf("t3_relock%0d", i + 1), locked, (i == 4) ? 1 : 0);
    end
    check_eq("t3_count_after", error_count, 3);
    check_eq("t3_error_after", error, 0);

    // 4: all-zero beats never lock
    do_reset();
    for (int i = 0; i < 50; i++) begin
      beat(1'b1, 8'h00, 1'b0);
      check_eq("t4_unlocked", locked, 0);
    end
    check_eq("t4_count", error_count, 0);

    // 5: valid every other cycle; idle cycles carry junk that must be ignored
    do_reset();
    g = 8'h01;
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, g, 1'b0);
      g = gen_step(g);
      check_eq($sformatf("t5_lock_v%0d", i + 1), locked, (i == 4) ? 1 : 0);
      beat(1'b0, 8'hA5, 1'b0);
      check_eq("t5_idle_err", error, 0);
    end
    for (int i = 0; i < 20; i++) begin
      beat(1'b1, g, 1'b0);
      g = gen_step(g);
      check_eq("t5_err", error, 0);
      beat(1'b0, 8'h5A, 1'b0);
    end
    check_eq("t5_count", error_count, 0);
    check_eq("t5_locked", locked, 1);

    // 6: saturation of the 4-bit counter, clear priority, async reset
    for (int i = 0; i < 20; i++) begin
      beat(1'b1, g ^ 8'h01, 1'b0);
      g = gen_step(g);
      beat(1'b1, g, 1'b0);
      g = gen_step(g);
    end
    check_eq("t6_sat4", error_count4, 15);
    check_eq("t6_count16", error_count, 20);
    check_eq("t6_locked4", locked4, 1);
    check_eq("t6_locked16", locked, 1);
    beat(1'b1, g ^ 8'h01, 1'b1);
    g = gen_step(g);
    check_eq("t6_clear4", error_count4, 0);
    check_eq("t6_clear16", error_count, 0);
    check_eq("t6_clear_err", error, 0);
    check_eq("t6_clear_locked", locked, 1);
    beat(1'b1, g ^ 8'h01, 1'b0);
    g = gen_step(g);
    check_eq("t6_pre_err", error, 1);
    check_eq("t6_pre_count4", error_count4, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("t6_rst_locked", locked, 0);
    check_eq("t6_rst_locked4", locked4, 0);
    check_eq("t6_rst_error", error, 0);
    check_eq("t6_rst_count4", error_count4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
